// File: rtl/xlr_gpp_bank.sv
// xlr_gpp_bank: host-visible register bank that snapshots parameters into a
// shadow copy for an accelerator, launches it, and captures its results.
module xlr_gpp_bank #(
    parameter int unsigned N_REGS = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned IDX_W = $clog2(N_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_wr_en,
    input  logic [IDX_W-1:0]         host_wr_idx,
    input  logic [DATA_W-1:0]        host_wr_data,
    input  logic [IDX_W-1:0]         host_rd_idx,
    output logic [DATA_W-1:0]        host_rd_data,
    input  logic                     host_start,
    output logic [N_REGS*DATA_W-1:0] xlr_regs,
    output logic                     xlr_start,
    input  logic                     xlr_done,
    input  logic [N_REGS*DATA_W-1:0] xlr_res,
    output logic                     busy,
    output logic                     done_irq,
    output logic                     start_err,
    output logic [CNT_W-1:0]         busy_cycles
);

    typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StCapture} state_e;

    // One extra bit so N_REGS itself is representable for the range check.
    localparam logic [IDX_W:0] NRegsW = (IDX_W + 1)'(N_REGS);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   host_q   [N_REGS];
    logic [DATA_W-1:0]   shadow_q [N_REGS];
    logic [DATA_W-1:0]   res_q    [N_REGS];
    logic [DATA_W-1:0]   rd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    busy_cycles_q;
    logic                start_err_q;

    logic wr_ok, rd_ok, accept, capture;

    assign wr_ok   = host_wr_en && ({1'b0, host_wr_idx} < NRegsW);
    assign rd_ok   = {1'b0, host_rd_idx} < NRegsW;
    assign accept  = (state_q == StIdle) && host_start;
    assign capture = (state_q == StBusy) && xlr_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (host_start) state_d = StLaunch;
            StLaunch:  state_d = StBusy;
            StBusy:    if (xlr_done) state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Host registers, shadow snapshot and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                host_q[i]   <= '0;
                shadow_q[i] <= '0;
                res_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (wr_ok && (host_wr_idx == IDX_W'(i))) begin
                    host_q[i] <= host_wr_data;
                end
                // Snapshot lands on the edge into LAUNCH so the shadow is valid
                // alongside xlr_start; a same-cycle write is forwarded in.
                if (accept) begin
                    shadow_q[i] <= (wr_ok && (host_wr_idx == IDX_W'(i))) ? host_wr_data
                                                                          : host_q[i];
                end
                if (capture) begin
                    res_q[i] <= xlr_res[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Busy counter, last-run duration, sticky start error and readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            busy_cycles_q <= '0;
            start_err_q   <= 1'b0;
            rd_q          <= '0;
        end else begin
            if (state_q == StLaunch) begin
                cnt_q <= '0;
            end else if ((state_q == StBusy) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == StCapture) begin
                busy_cycles_q <= cnt_q;
            end
            if (accept) begin
                start_err_q <= 1'b0;
            end else if (host_start) begin
                start_err_q <= 1'b1;
            end
            rd_q <= rd_ok ? res_q[host_rd_idx] : '0;
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_flat
        assign xlr_regs[g*DATA_W +: DATA_W] = shadow_q[g];
    end

    assign xlr_start    = (state_q == StLaunch);
    assign busy         = (state_q == StLaunch) || (state_q == StBusy);
    assign done_irq     = (state_q == StCapture);
    assign start_err    = start_err_q;
    assign busy_cycles  = busy_cycles_q;
    assign host_rd_data = rd_q;

endmodule

// File: tb/tb_xlr_gpp_bank.sv
// Directed bench for xlr_gpp_bank; a second instance with CNT_W=4 shares the
// stimulus and is used for the counter-saturation check.
module tb_xlr_gpp_bank;

    localparam int N = 8;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           host_wr_en;
    logic [2:0]     host_wr_idx;
    logic [W-1:0]   host_wr_data;
    logic [2:0]     host_rd_idx;
    logic           host_start;
    logic           xlr_done;
    logic [N*W-1:0] xlr_res;

    logic [W-1:0]   host_rd_data, host_rd_data4;
    logic [N*W-1:0] xlr_regs, xlr_regs4;
    logic           xlr_start, xlr_start4, busy, busy4, done_irq, done_irq4;
    logic           start_err, start_err4;
    logic [15:0]    busy_cycles;
    logic [3:0]     busy_cycles4;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] host_m [N];

    typedef struct {
        logic [2:0]   idx;
        logic [W-1:0] data;
    } wr_vec_t;

    typedef struct {
        logic [2:0]   idx;
        logic [W-1:0] res;
        logic [W-1:0] exp;
    } rd_vec_t;

    wr_vec_t wr_tab [2];
    rd_vec_t rd_tab [8];

    always #5 clk = ~clk;

    xlr_gpp_bank #(.N_REGS(N), .DATA_W(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx),
        .host_wr_data(host_wr_data), .host_rd_idx(host_rd_idx), .host_rd_data(host_rd_data),
        .host_start(host_start), .xlr_regs(xlr_regs), .xlr_start(xlr_start),
        .xlr_done(xlr_done), .xlr_res(xlr_res), .busy(busy), .done_irq(done_irq),
        .start_err(start_err), .busy_cycles(busy_cycles)
    );

    xlr_gpp_bank #(.N_REGS(N), .DATA_W(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .host_wr_en(host_wr_en), .host_wr_idx(host_wr_idx),
        .host_wr_data(host_wr_data), .host_rd_idx(host_rd_idx), .host_rd_data(host_rd_data4),
        .host_start(host_start), .xlr_regs(xlr_regs4), .xlr_start(xlr_start4),
        .xlr_done(xlr_done), .xlr_res(xlr_res), .busy(busy4), .done_irq(done_irq4),
        .start_err(start_err4), .busy_cycles(busy_cycles4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a host write for the next edge and track it in the model.
    task automatic wr(input logic [2:0] idx, input logic [W-1:0] data);
        host_wr_en   = 1'b1;
        host_wr_idx  = idx;
        host_wr_data = data;
        host_m[idx]  = data;
    endtask

    task automatic check_snap(input string name);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s regs[%0d]", name, i), xlr_regs[i*W +: W], host_m[i]);
        end
    endtask

    initial begin
        wr_tab[0] = '{idx: 3'd0, data: 32'hA5A5_A5A5};
        wr_tab[1] = '{idx: 3'd3, data: 32'h0000_0001};
        rd_tab[0] = '{idx: 3'd0, res: 32'h1000_0000, exp: 32'h1000_0000};
        rd_tab[1] = '{idx: 3'd1, res: 32'h1000_0001, exp: 32'h1000_0001};
        rd_tab[2] = '{idx: 3'd2, res: 32'h0000_DEAD, exp: 32'h0000_DEAD};
        rd_tab[3] = '{idx: 3'd3, res: 32'h1000_0003, exp: 32'h1000_0003};
        rd_tab[4] = '{idx: 3'd4, res: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
        rd_tab[5] = '{idx: 3'd5, res: 32'h0000_0000, exp: 32'h0000_0000};
        rd_tab[6] = '{idx: 3'd6, res: 32'h8000_0001, exp: 32'h8000_0001};
        rd_tab[7] = '{idx: 3'd7, res: 32'h5A5A_0007, exp: 32'h5A5A_0007};
        for (int i = 0; i < N; i++) host_m[i] = '0;

        rst_n = 1'b0; host_wr_en = 0; host_wr_idx = 0; host_wr_data = 0;
        host_rd_idx = 0; host_start = 0; xlr_done = 0; xlr_res = '0;

        // Reset state
        #3;
        chk("rst xlr_start", {xlr_start, xlr_start4}, 0);
        chk("rst busy", {busy, busy4}, 0);
        chk("rst done_irq", {done_irq, done_irq4}, 0);
        chk("rst start_err", {start_err, start_err4}, 0);
        chk("rst busy_cycles", {busy_cycles, busy_cycles4}, 0);
        chk("rst rd_data", {host_rd_data, host_rd_data4}, 0);
        chk("rst regs", {|xlr_regs, |xlr_regs4}, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Register writes then start; launch pulse one cycle later
        for (int v = 0; v < 2; v++) begin
            wr(wr_tab[v].idx, wr_tab[v].data);
            step();
        end
        host_wr_en = 0;
        host_start = 1;
        chk("idle xlr_start", xlr_start, 0);
        step();
        host_start = 0;
        chk("launch xlr_start", xlr_start, 1);
        chk("launch busy", busy, 1);
        check_snap("first");
        chk("dut4 snapshot", xlr_regs4, xlr_regs);

        // Done five cycles after xlr_start with a result table
        for (int i = 0; i < N; i++) xlr_res[i*W +: W] = rd_tab[i].res;
        repeat (5) step();
        chk("busy before done", busy, 1);
        chk("xlr_start single", xlr_start, 0);
        xlr_done = 1;
        step();
        xlr_done = 0;
        xlr_res = '0;
        chk("capture irq", done_irq, 1);
        chk("capture busy", busy, 0);
        host_rd_idx = 3'd2;
        step();
        chk("irq single", done_irq, 0);
        chk("busy_cycles 5", busy_cycles, 5);
        chk("busy_cycles4 5", busy_cycles4, 5);
        chk("readback 2", host_rd_data, 32'h0000_DEAD);
        for (int v = 0; v < 8; v++) begin
            host_rd_idx = rd_tab[v].idx;
            step();
            chk($sformatf("readback tab %0d", v), host_rd_data, rd_tab[v].exp);
        end

        // Done in IDLE is ignored
        xlr_res = {N{32'h1234_5678}};
        xlr_done = 1;
        host_rd_idx = 3'd2;
        step();
        xlr_done = 0;
        chk("idle done irq", done_irq, 0);
        step();
        chk("idle done no capture", host_rd_data, 32'h0000_DEAD);

        // Start and write during BUSY: start rejected, shadow untouched
        host_start = 1;
        step();
        host_start = 0;
        step();
        host_start = 1;
        wr(3'd1, 32'h77);
        step();
        host_start = 0; host_wr_en = 0;
        chk("busy start_err", start_err, 1);
        chk("busy regs1 held", xlr_regs[1*W +: W], 0);
        chk("busy still busy", busy, 1);
        xlr_done = 1;
        step();
        xlr_done = 0;
        step();
        chk("start_err sticky", start_err, 1);

        // Accepted start with same-cycle write: clears error, shows both writes
        host_start = 1;
        wr(3'd5, 32'h12);
        step();
        host_start = 0; host_wr_en = 0;
        chk("restart xlr_start", xlr_start, 1);
        chk("restart err clr", start_err, 0);
        check_snap("second");

        // Twenty-cycle run saturates the 4-bit counter
        step();
        repeat (19) step();
        xlr_done = 1;
        step();
        xlr_done = 0;
        step();
        chk("busy_cycles 20", busy_cycles, 20);
        chk("busy_cycles4 sat", busy_cycles4, 15);

        // Minimum start-to-start spacing: done on first BUSY cycle
        host_start = 1;
        step();
        host_start = 0;
        step();
        xlr_done = 1;
        step();
        xlr_done = 0;
        chk("fast capture irq", done_irq, 1);
        step();
        host_start = 1;
        step();
        host_start = 0;
        chk("spacing relaunch", xlr_start, 1);
        chk("spacing no err", start_err, 0);
        chk("busy_cycles 1", busy_cycles, 1);

        // Reset mid-run: outputs drop immediately, run abandoned
        step();
        host_start = 1;
        step();
        host_start = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", {busy, busy4}, 0);
        chk("midrst xlr_start", {xlr_start, xlr_start4}, 0);
        chk("midrst irq", {done_irq, done_irq4}, 0);
        chk("midrst err", {start_err, start_err4}, 0);
        chk("midrst cycles", {busy_cycles, busy_cycles4}, 0);
        chk("midrst rd", {host_rd_data, host_rd_data4}, 0);
        chk("midrst regs", {|xlr_regs, |xlr_regs4}, 0);
        xlr_done = 1;
        step();
        chk("in-rst irq", done_irq, 0);
        rst_n = 1'b1;
        xlr_done = 0;
        host_rd_idx = 3'd2;
        step();
        chk("post-rst idle", {busy, xlr_start}, 0);
        xlr_done = 1;
        step();
        xlr_done = 0;
        chk("post-rst done irq", done_irq, 0);
        step();
        chk("post-rst rd", host_rd_data, 0);
        chk("post-rst irq2", done_irq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xlr_gpp_bank.md
XLR_GPP_BANK -- requirements
Module: xlr_gpp_bank

Interface
REQ-001 The block SHALL have parameter N_REGS, default 8, giving the number of general-purpose register channels (2..64).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the bit width of each channel (8..64).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the busy-cycle counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port host_wr_en, input, 1 bit: host register write strobe.
REQ-007 The block SHALL have port host_wr_idx, input, IDX_W=$clog2(N_REGS) bits: write channel index.
REQ-008 The block SHALL have port host_wr_data, input, DATA_W bits: write data.
REQ-009 The block SHALL have port host_rd_idx, input, IDX_W bits: read channel index.
REQ-010 The block SHALL have port host_rd_data, output, DATA_W bits: registered result-register readback.
REQ-011 The block SHALL have port host_start, input, 1 bit: single-cycle request to launch the accelerator.
REQ-012 The block SHALL have port xlr_regs, output, N_REGS*DATA_W bits: flattened shadow copy presented to the accelerator, with channel i at [i*DATA_W +: DATA_W].
REQ-013 The block SHALL have port xlr_start, output, 1 bit: single-cycle launch pulse to the accelerator.
REQ-014 The block SHALL have port xlr_done, input, 1 bit: accelerator completion pulse.
REQ-015 The block SHALL have port xlr_res, input, N_REGS*DATA_W bits: flattened accelerator results, sampled when xlr_done=1.
REQ-016 The block SHALL have port busy, output, 1 bit: high from the xlr_start cycle until the result capture.
REQ-017 The block SHALL have port done_irq, output, 1 bit: single-cycle completion pulse to the host.
REQ-018 The block SHALL have port start_err, output, 1 bit: sticky flag set when a start is rejected.
REQ-019 The block SHALL have port busy_cycles, output, CNT_W bits: busy duration of the last completed run.

Function
REQ-020 The block SHALL hold N_REGS host registers; when host_wr_en=1, host_wr_data SHALL be written to the register at host_wr_idx on that edge in every state; an index >= N_REGS SHALL be ignored.
REQ-021 The block SHALL implement the FSM IDLE -> LAUNCH -> BUSY -> CAPTURE -> IDLE.
REQ-022 In IDLE, host_start=1 SHALL move the FSM to LAUNCH; a same-cycle host write SHALL be included in the snapshot (write-before-snapshot forwarding).
REQ-023 In LAUNCH (exactly 1 cycle), the block SHALL copy all host registers into the xlr_regs shadow, assert xlr_start, set busy, clear the busy counter, and go to BUSY.
REQ-024 xlr_regs SHALL change only in LAUNCH; host writes in LAUNCH, BUSY or CAPTURE SHALL update the host registers only.
REQ-025 In BUSY, the counter SHALL increment every cycle, saturating at 2^CNT_W-1; xlr_done=1 SHALL latch xlr_res into the N_REGS result registers and move the FSM to CAPTURE.
REQ-026 In CAPTURE (1 cycle), the block SHALL pulse done_irq, copy the counter to busy_cycles, deassert busy, and return to IDLE.
REQ-027 xlr_done outside BUSY SHALL be ignored, with no capture and no irq.
REQ-028 host_start in LAUNCH, BUSY or CAPTURE SHALL be ignored and SHALL set start_err; start_err SHALL clear only on the next accepted start.
REQ-029 host_rd_data SHALL equal result register[host_rd_idx] one cycle after host_rd_idx is presented, and 0 for an index >= N_REGS.
REQ-030 Start-to-start minimum spacing SHALL be 4 cycles (LAUNCH, BUSY with done on its first cycle, CAPTURE, IDLE).

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously enter IDLE and clear all host, shadow and result registers to 0.
REQ-032 On rst_n=0 host_rd_data, xlr_start, busy, done_irq, start_err and busy_cycles SHALL all be 0 until release.
REQ-033 Reset asserted in mid-run SHALL abandon the run without a done_irq; the first edge after release SHALL be in IDLE.

Verification
REQ-034 The bench SHALL write reg0=0xA5A5A5A5 and reg3=0x1 (N_REGS=8), then start: xlr_start pulses on the cycle after start, xlr_regs[0]=0xA5A5A5A5, [3]=1, all others 0.
REQ-035 The bench SHALL drive xlr_done 5 cycles after xlr_start with res[2]=0xDEAD: done_irq pulses once, busy_cycles=5, and reading index 2 returns 0xDEAD one cycle later.
REQ-036 The bench SHALL issue host_start and write reg1=0x77 during BUSY: start_err=1, xlr_regs[1] unchanged; the next accepted start clears start_err and shows 0x77.
REQ-037 The bench SHALL write reg5=0x12 and start in the same cycle: the snapshot shows 0x12.
REQ-038 The bench SHALL run with CNT_W=4 and xlr_done after 20 cycles: busy_cycles=15 (saturated).
REQ-039 The bench SHALL assert rst_n=0 while BUSY: busy=0 immediately, no done_irq, all outputs 0; a later xlr_done is ignored.
